// File: rtl/wb_mst_engine_if.sv
// Wishbone classic bus bundle between the engine (master) and a slave.
//   adr/dout/sel/we/cyc/stb : master -> slave request signals
//   din/ack/err/rty         : slave -> master response signals
interface wb_mst_engine_if;
  logic [31:0] adr;
  logic [31:0] dout;
  logic [31:0] din;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output adr, dout, sel, we, cyc, stb,
    input  din, ack, err, rty
  );

  modport slave (
    input  adr, dout, sel, we, cyc, stb,
    output din, ack, err, rty
  );
endinterface

// File: rtl/wb_mst_engine.sv
// Wishbone classic initiator. Converts single-word or incrementing-burst
// commands into Wishbone cycles, streams write data in / read data out, and
// reports per-command completion status.
//   clk, rst        : clock, synchronous active-low reset
//   cmd_*           : command port (valid/ready), we, start address, sel, len-1
//   wd_*            : write data stream into the engine
//   rd_valid/rd_data: read data beats (one-cycle pulse per beat)
//   done/status     : completion pulse; status 0=OK 1=ERR 2=RTY exhausted 3=TIMEOUT
//   wb              : Wishbone master modport
// Optional build macro WB_MST_WDOG_EN: bus watchdog aborting after TIMEOUT
// consecutive unanswered strobe cycles.
module wb_mst_engine #(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [3:0]       cmd_sel,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wd_valid,
  output logic             wd_ready,
  input  logic [31:0]      wd_data,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  output logic             done,
  output logic [1:0]       status,
  wb_mst_engine_if.master  wb
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDAT,
    S_BUS,
    S_BACKOFF,
    S_DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] beats;
  // One bit wider than MAX_RETRY's range so count MAX_RETRY+1 is representable.
  logic [4:0]       retry;

`ifdef WB_MST_WDOG_EN
  localparam int unsigned WDOG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [WDOG_W-1:0] wdog;
`endif

  assign cmd_ready = (state == S_IDLE);
  assign wd_ready  = (state == S_WDAT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      beats    <= '0;
      retry    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
      status   <= '0;
      wb.adr   <= '0;
      wb.dout  <= '0;
      wb.sel   <= '0;
      wb.we    <= 1'b0;
      wb.cyc   <= 1'b0;
      wb.stb   <= 1'b0;
`ifdef WB_MST_WDOG_EN
      wdog     <= '0;
`endif
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
`ifdef WB_MST_WDOG_EN
      // Cleared everywhere except a silent BUS cycle, which increments below.
      wdog     <= '0;
`endif
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            wb.adr <= cmd_adr & 32'hFFFF_FFFC;
            wb.sel <= cmd_sel;
            wb.we  <= cmd_we;
            wb.cyc <= 1'b1;
            beats  <= cmd_len;
            retry  <= '0;
            if (cmd_we) begin
              state <= S_WDAT;
            end else begin
              wb.stb <= 1'b1;
              state  <= S_BUS;
            end
          end
        end

        S_WDAT: begin
          if (wd_valid) begin
            wb.dout <= wd_data;
            wb.stb  <= 1'b1;
            state   <= S_BUS;
          end
        end

        S_BUS: begin
          if (wb.err) begin
            wb.cyc <= 1'b0;
            wb.stb <= 1'b0;
            status <= 2'd1;
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (wb.rty) begin
            wb.stb <= 1'b0;
            retry  <= retry + 5'd1;
            if ((retry + 5'd1) > 5'(MAX_RETRY)) begin
              wb.cyc <= 1'b0;
              status <= 2'd2;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              state <= S_BACKOFF;
            end
          end else if (wb.ack) begin
            if (!wb.we) begin
              rd_data  <= wb.din;
              rd_valid <= 1'b1;
            end
            if (beats != '0) begin
              retry  <= '0;
              wb.adr <= wb.adr + 32'd4;
              beats  <= beats - LEN_W'(1);
              // Reads keep stb high for back-to-back beats; writes drop it to
              // fetch the next data word.
              if (wb.we) begin
                wb.stb <= 1'b0;
                state  <= S_WDAT;
              end
            end else begin
              wb.cyc <= 1'b0;
              wb.stb <= 1'b0;
              status <= 2'd0;
              done   <= 1'b1;
              state  <= S_DONE;
            end
          end
`ifdef WB_MST_WDOG_EN
          // Abort on the TIMEOUT-th consecutive strobe cycle without response.
          else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
            wb.cyc <= 1'b0;
            wb.stb <= 1'b0;
            status <= 2'd3;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
`endif
        end

        S_BACKOFF: begin
          wb.stb <= 1'b1;
          state  <= S_BUS;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          wb.cyc <= 1'b0;
          wb.stb <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
